cw_packer: RTL and testbench



---
 rtl/cw_packer.sv | 102 ++++++++++
 tb/tb_cw_packer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cw_packer.sv
// Packs 38-bit codewords LSB-first into OUT_W-bit words; a word is visible the cycle after the push that completes it. Optional counters: CW_PACKER_STATS_EN.
// Backpressure: out_ready=0 holds out_data; in_ready drops when a codeword no longer fits, and a codeword offered while in_ready=0 is dropped and sets ovf.
module cw_packer #(
    parameter int CW_W  = 38,
    parameter int OUT_W = 16,
    parameter int ACC_W = 64,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cw_valid,
    input  logic [CW_W-1:0]  cw_data,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             flush_done,
    output logic             ovf
`ifdef CW_PACKER_STATS_EN
    ,
    output logic [15:0]      cw_count,
    output logic [15:0]      word_count
`endif
);

    typedef enum logic {NORMAL, FLUSHING} state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] fill;
    logic [ACC_W-1:0] acc_nxt;
    logic [CNT_W-1:0] fill_nxt;
    logic             pop;
    logic             push;
    logic             flushing_nxt;

    assign out_valid    = (fill >= CNT_W'(OUT_W));
    assign out_data     = acc[OUT_W-1:0];
    assign in_ready     = (state == NORMAL) && (fill <= CNT_W'(ACC_W - CW_W));
    assign pop          = out_valid && out_ready;
    assign push         = cw_valid && in_ready;
    assign flushing_nxt = (state == FLUSHING) || flush;

    // Bits above fill are always zero, so OR-ing in the new codeword is safe
    // and raising fill to OUT_W during a flush is the zero pad.
    always_comb begin
        acc_nxt  = acc;
        fill_nxt = fill;
        if (pop) begin
            acc_nxt  = acc >> OUT_W;
            fill_nxt = fill - CNT_W'(OUT_W);
        end
        if (push) begin
            acc_nxt  = acc_nxt | ({{(ACC_W - CW_W){1'b0}}, cw_data} << fill_nxt);
            fill_nxt = fill_nxt + CNT_W'(CW_W);
        end
        if (flushing_nxt && (fill_nxt != '0) && (fill_nxt < CNT_W'(OUT_W))) begin
            fill_nxt = CNT_W'(OUT_W);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            fill       <= '0;
            state      <= NORMAL;
            flush_done <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            acc        <= acc_nxt;
            fill       <= fill_nxt;
            flush_done <= 1'b0;
            if (cw_valid && !in_ready) begin
                ovf <= 1'b1;
            end
            if (flushing_nxt && (fill_nxt == '0)) begin
                state      <= NORMAL;
                flush_done <= 1'b1;
            end else if (flushing_nxt) begin
                state <= FLUSHING;
            end
        end
    end

`ifdef CW_PACKER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cw_count   <= '0;
            word_count <= '0;
        end else begin
            if (push && (cw_count != 16'hFFFF)) begin
                cw_count <= cw_count + 16'd1;
            end
            if (pop && (word_count != 16'hFFFF)) begin
                word_count <= word_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cw_packer.sv
module tb_cw_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cw_valid;
    logic [37:0] cw_data;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        flush_done;
    logic        ovf;
`ifdef CW_PACKER_STATS_EN
    logic [15:0] cw_count;
    logic [15:0] word_count;
    int          m_cws;
    int          m_words;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Reference: the buffered stream as a plain bit queue, oldest bit first.
    bit q[$];
    bit m_flushing;
    bit m_ovf;
    bit m_done;

    cw_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cw_valid   (cw_valid),
        .cw_data    (cw_data),
        .in_ready   (in_ready),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .flush_done (flush_done),
        .ovf        (ovf)
`ifdef CW_PACKER_STATS_EN
        ,
        .cw_count   (cw_count),
        .word_count (word_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_word();
        logic [15:0] w;
        w = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < q.size()) w[i] = q[i];
        end
        return w;
    endfunction

    task automatic check_outputs();
        check("out_valid", 32'(out_valid), 32'(q.size() >= 16));
        check("out_data", 32'(out_data), 32'(exp_word()));
        check("in_ready", 32'(in_ready), 32'(!m_flushing && q.size() <= 26));
        check("flush_done", 32'(flush_done), 32'(m_done));
        check("ovf", 32'(ovf), 32'(m_ovf));
`ifdef CW_PACKER_STATS_EN
        check("cw_count", 32'(cw_count), 32'(m_cws));
        check("word_count", 32'(word_count), 32'(m_words));
`endif
    endtask

    task automatic model_step(input logic v, input logic [37:0] d, input logic f, input logic ordy);
        bit rdy;
        bit pp;
        bit b;
        rdy = !m_flushing && (q.size() <= 26);
        pp  = (q.size() >= 16) && ordy;
        if (v && !rdy) m_ovf = 1'b1;
        if (pp) begin
            for (int i = 0; i < 16; i++) b = q.pop_front();
`ifdef CW_PACKER_STATS_EN
            m_words++;
`endif
        end
        if (v && rdy) begin
            for (int i = 0; i < 38; i++) q.push_back(d[i]);
`ifdef CW_PACKER_STATS_EN
            m_cws++;
`endif
        end
        if (f) m_flushing = 1'b1;
        m_done = 1'b0;
        if (m_flushing) begin
            while (q.size() > 0 && q.size() < 16) q.push_back(1'b0);
            if (q.size() == 0) begin
                m_flushing = 1'b0;
                m_done     = 1'b1;
            end
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_flushing = 1'b0;
        m_ovf      = 1'b0;
        m_done     = 1'b0;
`ifdef CW_PACKER_STATS_EN
        m_cws   = 0;
        m_words = 0;
`endif
    endtask

    // Drive one clock's inputs and compare the outputs held since the last edge.
    task automatic cycle(input logic v, input logic [37:0] d, input logic f, input logic ordy);
        @(negedge clk);
        check_outputs();
        cw_valid  = v;
        cw_data   = d;
        flush     = f;
        out_ready = ordy;
        @(posedge clk);
        model_step(v, d, f, ordy);
    endtask

    task automatic idle_inputs();
        cw_valid  = 1'b0;
        cw_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [37:0] d;
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        do_reset();

        // Reset state and quiet idle period.
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_flush_done", 32'(flush_done), 32'd0);
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b0, 1'b1);

        // Single codeword, two full words, then flush of the 6-bit remainder.
        cycle(1'b1, 38'h15_5555_5555, 1'b0, 1'b1);
        #1 check("t2_w0", 32'(out_data), 32'h5555);
        check("t2_v0", 32'(out_valid), 32'd1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        #1 check("t2_w1", 32'(out_data), 32'h5555);
        check("t2_v1", 32'(out_valid), 32'd1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        #1 check("t2_held", 32'(out_valid), 32'd0);
        cycle(1'b0, '0, 1'b1, 1'b1);
        #1 check("t2_pad", 32'(out_data), 32'h0015);
        check("t2_pad_v", 32'(out_valid), 32'd1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        #1 check("t2_done", 32'(flush_done), 32'd1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        #1 check("t2_done_pulse", 32'(flush_done), 32'd0);

        // Flush of an empty buffer completes on the next cycle.
        cycle(1'b0, '0, 1'b1, 1'b1);
        #1 check("empty_flush_done", 32'(flush_done), 32'd1);

        // Encoder cadence: one random codeword every fourth cycle.
        for (int k = 0; k < 64; k++) begin
            d = {$urandom(), $urandom()};
            #1 check("cad_in_ready", 32'(in_ready), 32'd1);
            cycle(1'b1, d, 1'b0, 1'b1);
            for (int j = 0; j < 3; j++) cycle(1'b0, '0, 1'b0, 1'b1);
        end
        check("cad_ovf", 32'(ovf), 32'd0);
        cycle(1'b0, '0, 1'b1, 1'b1);
        for (int j = 0; j < 6; j++) cycle(1'b0, '0, 1'b0, 1'b1);

        // Backpressure: the head word must not move while out_ready is low.
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 38'h15_5555_5555, 1'b0, 1'b0);
            #1 check("bp_hold", 32'(out_data), 32'h5555);
            for (int j = 0; j < 3; j++) cycle(1'b0, '0, 1'b0, 1'b0);
            #1 check("bp_hold2", 32'(out_data), 32'h5555);
        end
        check("bp_ovf", 32'(ovf), 32'd1);
        cycle(1'b0, '0, 1'b1, 1'b1);
        for (int j = 0; j < 8; j++) cycle(1'b0, '0, 1'b0, 1'b1);
        check("bp_ovf_sticky", 32'(ovf), 32'd1);

        // Random traffic: simultaneous push/pop, stalls, flushes, overflows.
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            d = {$urandom(), $urandom()};
            cycle(($urandom_range(0, 3) == 0), d, ($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 3) != 0));
        end

        // Reset while a flush is stalled with buffered bits.
        do_reset();
        cycle(1'b1, {$urandom(), $urandom()}, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_data", 32'(out_data), 32'd0);
        check("mid_rst_flush_done", 32'(flush_done), 32'd0);
        check("mid_rst_ovf", 32'(ovf), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        d = {$urandom(), $urandom()};
        cycle(1'b1, d, 1'b0, 1'b0);
        #1 check("post_rst_bit0", 32'(out_data), 32'(d[15:0]));
        for (int j = 0; j < 6; j++) cycle(1'b0, '0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
